// File: rtl/execute_stage.sv
// execute_stage: execute (A) stage of the 5-stage RV32 pipeline.
//   Resolves operand forwarding from ac / cm / writeback. ADD, ADDI, SLL and
//   load/store address generation complete in one cycle. MUL runs on an
//   iterative shift-add unit, one multiplier bit per cycle.
//
// Ports
//   clock, reset                 clock, synchronous active-high reset
//   dcache_stall, icache_stall   global freeze; ac_* and multiplier hold
//   da_*                         decode pipeline register (operands, control)
//   cm_is_wb/write_sel/result    memory-stage result for forwarding
//   w_regfile/sel/data_regfile   writeback port for forwarding
//   ac_*                         registered execute results to memory stage
//   mul_stall                    combinational; freezes pipeline during MUL
//
// Multiplier states
//   state | meaning
//   IDLE  | no multiply in flight; a MUL in da captures operands
//   BUSY  | shift-add iterating, one multiplier bit per unfrozen cycle
//   DONE  | product valid in acc; ac latches it on the next unfrozen edge
module execute_stage #(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dcache_stall,
  input  logic        icache_stall,
  input  logic [31:0] da_pc,
  input  logic [4:0]  da_write_sel,
  input  logic [4:0]  da_read_sel1,
  input  logic [4:0]  da_read_sel2,
  input  logic        da_is_wb,
  input  logic        da_is_load,
  input  logic        da_is_store,
  input  logic        da_is_imm,
  input  logic [31:0] da_data1,
  input  logic [31:0] da_data2,
  input  logic [31:0] da_imm32,
  input  logic [5:0]  da_ALU_Control,
  input  logic        cm_is_wb,
  input  logic [4:0]  cm_write_sel,
  input  logic [31:0] cm_result,
  input  logic        w_regfile,
  input  logic [4:0]  sel_regfile,
  input  logic [31:0] data_regfile,
  output logic [31:0] ac_pc,
  output logic [31:0] ac_result,
  output logic [31:0] ac_store_data,
  output logic [4:0]  ac_write_sel,
  output logic        ac_is_wb,
  output logic        ac_is_load,
  output logic        ac_is_store,
  output logic        mul_stall
);

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  localparam logic [5:0] ALU_ADD = 6'b000000;
  localparam logic [5:0] ALU_SLL = 6'b000001;
  localparam logic [5:0] ALU_MUL = 6'b000010;
  localparam logic [5:0] ALU_STA = 6'b011111;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_e;

  mul_state_e       state_q, state_d;
  logic [31:0]      mcand_q, mcand_d;
  logic [31:0]      mplier_q, mplier_d;
  logic [31:0]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] ac_pc_q, ac_result_q, ac_store_data_q;
  logic [4:0]  ac_write_sel_q;
  logic        ac_is_wb_q, ac_is_load_q, ac_is_store_q;

  logic        freeze, is_mul, ac_en;
  logic        ac_fwd_ok, cm_fwd_ok, wb_fwd_ok;
  logic [31:0] fwd1, fwd2, op2b, alu_res;

  assign freeze = dcache_stall | icache_stall;
  assign is_mul = (da_ALU_Control == ALU_MUL);

  // A load in ac has no data yet; decode's load-use stall covers that case.
  assign ac_fwd_ok = ac_is_wb_q & ~ac_is_load_q & (ac_write_sel_q != 5'd0);
  assign cm_fwd_ok = cm_is_wb & (cm_write_sel != 5'd0);
  assign wb_fwd_ok = w_regfile & (sel_regfile != 5'd0);

  always_comb begin
    if (ac_fwd_ok && ac_write_sel_q == da_read_sel1)      fwd1 = ac_result_q;
    else if (cm_fwd_ok && cm_write_sel == da_read_sel1)   fwd1 = cm_result;
    else if (wb_fwd_ok && sel_regfile == da_read_sel1)    fwd1 = data_regfile;
    else                                                  fwd1 = da_data1;
  end

  always_comb begin
    if (ac_fwd_ok && ac_write_sel_q == da_read_sel2)      fwd2 = ac_result_q;
    else if (cm_fwd_ok && cm_write_sel == da_read_sel2)   fwd2 = cm_result;
    else if (wb_fwd_ok && sel_regfile == da_read_sel2)    fwd2 = data_regfile;
    else                                                  fwd2 = da_data2;
  end

  assign op2b = (da_is_imm | da_is_load | da_is_store) ? da_imm32 : fwd2;

  always_comb begin
    case (da_ALU_Control)
      ALU_ADD, ALU_STA: alu_res = fwd1 + op2b;
      ALU_SLL:          alu_res = fwd1 << op2b[4:0];
      // Only reaches ac in DONE: mul_stall blocks the ac update otherwise.
      ALU_MUL:          alu_res = acc_q;
      default:          alu_res = 32'd0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (is_mul && !freeze) begin
          mcand_d  = fwd1;
          mplier_d = fwd2;
          acc_d    = 32'd0;
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (!freeze) begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_d = DONE;
        end
      end
      DONE: begin
        if (!freeze) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Low in DONE so decode advances exactly once past the MUL.
  assign mul_stall = ((state_q == IDLE) && is_mul) || (state_q == BUSY);
  assign ac_en     = !freeze && !mul_stall;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
      acc_q    <= 32'd0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ac_pc_q         <= 32'd0;
      ac_result_q     <= 32'd0;
      ac_store_data_q <= 32'd0;
      ac_write_sel_q  <= 5'd0;
      ac_is_wb_q      <= 1'b0;
      ac_is_load_q    <= 1'b0;
      ac_is_store_q   <= 1'b0;
    end else if (ac_en) begin
      ac_pc_q         <= da_pc;
      ac_result_q     <= alu_res;
      ac_store_data_q <= fwd2;
      ac_write_sel_q  <= da_write_sel;
      ac_is_wb_q      <= da_is_wb;
      ac_is_load_q    <= da_is_load;
      ac_is_store_q   <= da_is_store;
    end
  end

  assign ac_pc         = ac_pc_q;
  assign ac_result     = ac_result_q;
  assign ac_store_data = ac_store_data_q;
  assign ac_write_sel  = ac_write_sel_q;
  assign ac_is_wb      = ac_is_wb_q;
  assign ac_is_load    = ac_is_load_q;
  assign ac_is_store   = ac_is_store_q;

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed vector table for single-cycle ops and forwarding,
// plus hand-written sequences for MUL timing, cache freeze and reset abort.
module tb_execute_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        dcache_stall, icache_stall;
  logic [31:0] da_pc;
  logic [4:0]  da_write_sel, da_read_sel1, da_read_sel2;
  logic        da_is_wb, da_is_load, da_is_store, da_is_imm;
  logic [31:0] da_data1, da_data2, da_imm32;
  logic [5:0]  da_ALU_Control;
  logic        cm_is_wb;
  logic [4:0]  cm_write_sel;
  logic [31:0] cm_result;
  logic        w_regfile;
  logic [4:0]  sel_regfile;
  logic [31:0] data_regfile;
  logic [31:0] ac_pc, ac_result, ac_store_data;
  logic [4:0]  ac_write_sel;
  logic        ac_is_wb, ac_is_load, ac_is_store;
  logic        mul_stall;

  int errors = 0;
  int checks = 0;

  execute_stage #(.MUL_CYCLES(32)) dut (
    .clock(clock), .reset(reset),
    .dcache_stall(dcache_stall), .icache_stall(icache_stall),
    .da_pc(da_pc), .da_write_sel(da_write_sel),
    .da_read_sel1(da_read_sel1), .da_read_sel2(da_read_sel2),
    .da_is_wb(da_is_wb), .da_is_load(da_is_load),
    .da_is_store(da_is_store), .da_is_imm(da_is_imm),
    .da_data1(da_data1), .da_data2(da_data2), .da_imm32(da_imm32),
    .da_ALU_Control(da_ALU_Control),
    .cm_is_wb(cm_is_wb), .cm_write_sel(cm_write_sel), .cm_result(cm_result),
    .w_regfile(w_regfile), .sel_regfile(sel_regfile), .data_regfile(data_regfile),
    .ac_pc(ac_pc), .ac_result(ac_result), .ac_store_data(ac_store_data),
    .ac_write_sel(ac_write_sel), .ac_is_wb(ac_is_wb),
    .ac_is_load(ac_is_load), .ac_is_store(ac_is_store),
    .mul_stall(mul_stall)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [5:0]  alu;
    logic [4:0]  wsel, rs1, rs2;
    logic        wb, ld, st, immf;
    logic [31:0] d1, d2, imm;
    logic        cmwb;
    logic [4:0]  cmsel;
    logic [31:0] cmres;
    logic        wwb;
    logic [4:0]  wsl;
    logic [31:0] wdat;
    logic [31:0] exp_res, exp_sd;
  } vec_t;

  function automatic vec_t mkv(input string nm, input logic [5:0] alu,
      input logic [4:0] wsel, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic wb, input logic ld, input logic st, input logic immf,
      input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
      input logic cmwb, input logic [4:0] cmsel, input logic [31:0] cmres,
      input logic wwb, input logic [4:0] wsl, input logic [31:0] wdat,
      input logic [31:0] exp_res, input logic [31:0] exp_sd);
    vec_t v;
    v.name = nm; v.alu = alu; v.wsel = wsel; v.rs1 = rs1; v.rs2 = rs2;
    v.wb = wb; v.ld = ld; v.st = st; v.immf = immf;
    v.d1 = d1; v.d2 = d2; v.imm = imm;
    v.cmwb = cmwb; v.cmsel = cmsel; v.cmres = cmres;
    v.wwb = wwb; v.wsl = wsl; v.wdat = wdat;
    v.exp_res = exp_res; v.exp_sd = exp_sd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input vec_t v, input logic [31:0] pc);
    da_pc = pc; da_ALU_Control = v.alu; da_write_sel = v.wsel;
    da_read_sel1 = v.rs1; da_read_sel2 = v.rs2;
    da_is_wb = v.wb; da_is_load = v.ld; da_is_store = v.st; da_is_imm = v.immf;
    da_data1 = v.d1; da_data2 = v.d2; da_imm32 = v.imm;
    cm_is_wb = v.cmwb; cm_write_sel = v.cmsel; cm_result = v.cmres;
    w_regfile = v.wwb; sel_regfile = v.wsl; data_regfile = v.wdat;
  endtask

  task automatic clear_da();
    drive(mkv("", 6'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0,
              0, 5'd0, 0, 0, 5'd0, 0, 0, 0), 32'd0);
  endtask

  // Steps a MUL already in da until mul_stall drops, optionally pulsing
  // dcache_stall during iteration n in [st_from, st_to), then checks the product.
  task automatic run_mul(input string nm, input int exp_cyc, input logic [31:0] exp_prod,
                         input logic [4:0] exp_wsel, input int st_from, input int st_to);
    int n;
    int held_bad;
    logic [31:0] held;
    n = 0;
    held_bad = 0;
    held = ac_result;
    #1;
    chk({nm, " stall_at_entry"}, {31'd0, mul_stall}, 32'd1);
    while (mul_stall && n < 200) begin
      dcache_stall = (n >= st_from) && (n < st_to);
      tick();
      n++;
      if (ac_result !== held) held_bad++;
    end
    dcache_stall = 1'b0;
    chk({nm, " stall_cycles"}, 32'(n), 32'(exp_cyc));
    chk({nm, " ac_held_while_busy"}, 32'(held_bad), 32'd0);
    tick();
    chk({nm, " product"}, ac_result, exp_prod);
    chk({nm, " wsel"}, {27'd0, ac_write_sel}, {27'd0, exp_wsel});
  endtask

  vec_t vt[$];

  initial begin
    reset = 1'b1;
    dcache_stall = 1'b0;
    icache_stall = 1'b0;
    clear_da();

    // alu, wsel, rs1, rs2, wb, ld, st, immf, d1, d2, imm, cmwb, cmsel, cmres, wwb, wsl, wdat, exp_res, exp_sd
    vt.push_back(mkv("addi_x5_7",     6'h00, 5'd5,  5'd0,  5'd0,  1,0,0,1, 32'h0, 32'h0, 32'd7, 0,5'd0,32'h0, 0,5'd0,32'h0, 32'd7, 32'd0));
    vt.push_back(mkv("add_ac_fwd",    6'h00, 5'd6,  5'd5,  5'd5,  1,0,0,0, 32'h0, 32'h0, 32'd0, 0,5'd0,32'h0, 0,5'd0,32'h0, 32'd14, 32'd7));
    vt.push_back(mkv("addi_x5_again", 6'h00, 5'd5,  5'd0,  5'd0,  1,0,0,1, 32'h0, 32'h0, 32'd7, 0,5'd0,32'h0, 0,5'd0,32'h0, 32'd7, 32'd0));
    vt.push_back(mkv("bubble",        6'h00, 5'd0,  5'd0,  5'd0,  0,0,0,0, 32'h0, 32'h0, 32'd0, 0,5'd0,32'h0, 0,5'd0,32'h0, 32'd0, 32'd0));
    vt.push_back(mkv("add_cm_fwd",    6'h00, 5'd6,  5'd5,  5'd5,  1,0,0,0, 32'h0, 32'h0, 32'd0, 1,5'd5,32'd7, 0,5'd0,32'h0, 32'd14, 32'd7));
    vt.push_back(mkv("addi_x7_3",     6'h00, 5'd7,  5'd0,  5'd0,  1,0,0,1, 32'h0, 32'h0, 32'd3, 0,5'd0,32'h0, 0,5'd0,32'h0, 32'd3, 32'd0));
    vt.push_back(mkv("prio_ac_over",  6'h00, 5'd8,  5'd7,  5'd0,  1,0,0,0, 32'h0, 32'h0, 32'd0, 1,5'd7,32'd100, 1,5'd7,32'd200, 32'd3, 32'd0));
    vt.push_back(mkv("prio_cm_over",  6'h00, 5'd9,  5'd10, 5'd11, 1,0,0,0, 32'h999, 32'd1000, 32'd0, 1,5'd10,32'd5, 1,5'd10,32'd50, 32'd1005, 32'd1000));
    vt.push_back(mkv("wb_fwd",        6'h00, 5'd0,  5'd12, 5'd13, 1,0,0,0, 32'h0, 32'd2, 32'd0, 1,5'd14,32'd1, 1,5'd12,32'd40, 32'd42, 32'd2));
    vt.push_back(mkv("x0_no_fwd",     6'h00, 5'd15, 5'd0,  5'd0,  1,0,0,0, 32'h11, 32'h22, 32'd0, 1,5'd0,32'd99, 1,5'd0,32'd77, 32'h33, 32'h22));
    vt.push_back(mkv("sll_mask",      6'h01, 5'd16, 5'd1,  5'd2,  1,0,0,0, 32'h1, 32'h25, 32'd0, 0,5'd0,32'h0, 0,5'd0,32'h0, 32'h20, 32'h25));
    vt.push_back(mkv("slli_3",        6'h01, 5'd16, 5'd1,  5'd0,  1,0,0,1, 32'h5, 32'h0, 32'd3, 0,5'd0,32'h0, 0,5'd0,32'h0, 32'h28, 32'h0));
    vt.push_back(mkv("unknown_op",    6'h03, 5'd17, 5'd3,  5'd4,  1,0,0,0, 32'h5, 32'h6, 32'd0, 0,5'd0,32'h0, 0,5'd0,32'h0, 32'h0, 32'h6));
    vt.push_back(mkv("store_fwd",     6'h1F, 5'd0,  5'd3,  5'd4,  0,0,1,0, 32'hDEAD, 32'hBEEF, 32'd8, 1,5'd3,32'h1000, 1,5'd4,32'hAB, 32'h1008, 32'hAB));
    vt.push_back(mkv("load_addr",     6'h00, 5'd9,  5'd14, 5'd0,  1,1,0,0, 32'h200, 32'h0, 32'h10, 0,5'd0,32'h0, 0,5'd0,32'h0, 32'h210, 32'h0));
    vt.push_back(mkv("no_fwd_load",   6'h00, 5'd18, 5'd9,  5'd0,  1,0,0,1, 32'h5, 32'h0, 32'd1, 0,5'd0,32'h0, 0,5'd0,32'h0, 32'h6, 32'h0));
    vt.push_back(mkv("add_wrap",      6'h00, 5'd19, 5'd20, 5'd21, 1,0,0,0, 32'hFFFFFFFF, 32'd2, 32'd0, 0,5'd0,32'h0, 0,5'd0,32'h0, 32'h1, 32'h2));

    tick();
    tick();
    reset = 1'b0;
    chk("reset ac_result", ac_result, 32'd0);
    chk("reset ac_pc", ac_pc, 32'd0);
    chk("reset ac_flags", {28'd0, ac_is_wb, ac_is_load, ac_is_store, mul_stall}, 32'd0);

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i], 32'h100 + 32'(i) * 4);
      tick();
      chk({vt[i].name, " result"}, ac_result, vt[i].exp_res);
      chk({vt[i].name, " store_data"}, ac_store_data, vt[i].exp_sd);
      chk({vt[i].name, " pc"}, ac_pc, 32'h100 + 32'(i) * 4);
      chk({vt[i].name, " wsel"}, {27'd0, ac_write_sel}, {27'd0, vt[i].wsel});
      chk({vt[i].name, " flags"}, {29'd0, ac_is_wb, ac_is_load, ac_is_store},
          {29'd0, vt[i].wb, vt[i].ld, vt[i].st});
    end

    // icache freeze of a plain ADD: ac holds, then updates once released
    drive(mkv("", 6'h00, 5'd23, 5'd0, 5'd0, 1,0,0,0, 32'd10, 32'd20, 32'd0,
              0,5'd0,0, 0,5'd0,0, 0, 0), 32'h200);
    icache_stall = 1'b1;
    tick();
    chk("icache hold result", ac_result, 32'h1);
    icache_stall = 1'b0;
    tick();
    chk("icache release result", ac_result, 32'd30);

    // MUL 0xFFFFFFFF * 3
    drive(mkv("", 6'h02, 5'd22, 5'd20, 5'd21, 1,0,0,0, 32'hFFFFFFFF, 32'd3, 32'd0,
              0,5'd0,0, 0,5'd0,0, 0, 0), 32'h300);
    run_mul("mul_neg1x3", 33, 32'hFFFFFFFD, 5'd22, 1000, 1000);

    // Back-to-back: 5*7 then x24*2 with x24 forwarded from ac
    drive(mkv("", 6'h02, 5'd24, 5'd25, 5'd26, 1,0,0,0, 32'd5, 32'd7, 32'd0,
              0,5'd0,0, 0,5'd0,0, 0, 0), 32'h304);
    run_mul("mul_5x7", 33, 32'd35, 5'd24, 1000, 1000);
    drive(mkv("", 6'h02, 5'd27, 5'd24, 5'd28, 1,0,0,0, 32'd0, 32'd2, 32'd0,
              0,5'd0,0, 0,5'd0,0, 0, 0), 32'h308);
    run_mul("mul_b2b_fwd", 33, 32'd70, 5'd27, 1000, 1000);

    // dcache freeze for 4 cycles during BUSY
    drive(mkv("", 6'h02, 5'd29, 5'd30, 5'd31, 1,0,0,0, 32'd12345, 32'd678, 32'd0,
              0,5'd0,0, 0,5'd0,0, 0, 0), 32'h30C);
    run_mul("mul_dstall", 37, 32'h007FB6F6, 5'd29, 5, 9);

    // Reset during BUSY aborts the multiply
    drive(mkv("", 6'h02, 5'd3, 5'd1, 5'd2, 1,0,0,0, 32'd9, 32'd9, 32'd0,
              0,5'd0,0, 0,5'd0,0, 0, 0), 32'h400);
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    clear_da();
    tick();
    tick();
    reset = 1'b0;
    chk("midmul reset ac_result", ac_result, 32'd0);
    chk("midmul reset ac_fields", {ac_pc[26:0], ac_write_sel}, 32'd0);
    chk("midmul reset flags", {28'd0, ac_is_wb, ac_is_load, ac_is_store, mul_stall}, 32'd0);
    drive(mkv("", 6'h00, 5'd1, 5'd0, 5'd0, 1,0,0,1, 32'd0, 32'd0, 32'd9,
              0,5'd0,0, 0,5'd0,0, 0, 0), 32'h404);
    #1;
    chk("post reset no stall", {31'd0, mul_stall}, 32'd0);
    tick();
    chk("post reset addi", ac_result, 32'd9);
    chk("post reset pc", ac_pc, 32'h404);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
